// File: rtl/ni_request_header_assembler.sv
// rtl/ni_request_header_assembler.sv - NI receive path: header reassembly from flits, then payload streaming
module ni_request_header_assembler #(
    parameter int FLIT_WIDTH    = 32,
    parameter int FTYPE_WIDTH   = 2,
    parameter int HEADER_FLITS  = 3,
    parameter int HEADER_LENGTH = 90,
    localparam int BASE_WIDTH   = FLIT_WIDTH - FTYPE_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [FLIT_WIDTH-1:0]    flit_in,
    input  logic                     flit_in_valid,
    output logic                     flit_in_ready,
    output logic [HEADER_LENGTH-1:0] header,
    output logic                     header_valid,
    input  logic                     header_accept,
    output logic                     header_only,
    output logic [BASE_WIDTH-1:0]    payload_data,
    output logic                     payload_valid,
    output logic                     payload_last,
    input  logic                     payload_ready,
    output logic                     proto_error
);

    localparam int CW    = $clog2(HEADER_FLITS + 1);
    localparam int BUF_W = BASE_WIDTH * HEADER_FLITS;
    localparam logic [CW-1:0] LAST_CNT = CW'(HEADER_FLITS);

    localparam logic [FTYPE_WIDTH-1:0] T_BODY      = FTYPE_WIDTH'(2'b00);
    localparam logic [FTYPE_WIDTH-1:0] T_TAIL      = FTYPE_WIDTH'(2'b01);
    localparam logic [FTYPE_WIDTH-1:0] T_HEAD      = FTYPE_WIDTH'(2'b10);
    localparam logic [FTYPE_WIDTH-1:0] T_HEAD_TAIL = FTYPE_WIDTH'(2'b11);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HDR      = 2'd1,
        HDR_WAIT = 2'd2,
        PAYLOAD  = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [BUF_W-1:0]  hdr_buf, hdr_next;
    logic [CW-1:0]     count, count_next;
    logic              only_q, only_next;
    logic              err_next;

    logic [FTYPE_WIDTH-1:0] ftype;
    logic [BASE_WIDTH-1:0]  fdata;
    logic                   fire;
    logic                   is_head;

    assign ftype   = flit_in[FLIT_WIDTH-1 -: FTYPE_WIDTH];
    assign fdata   = flit_in[BASE_WIDTH-1:0];
    assign fire    = flit_in_valid && flit_in_ready;
    assign is_head = (ftype == T_HEAD) || (ftype == T_HEAD_TAIL);

    assign header       = hdr_buf[HEADER_LENGTH-1:0];
    assign header_valid = (state == HDR_WAIT);
    assign header_only  = only_q;
    assign payload_data = fdata;

    // Registered state: FSM, header buffer, chunk counter, header_only and error pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            hdr_buf     <= '0;
            count       <= '0;
            only_q      <= 1'b0;
            proto_error <= 1'b0;
        end else begin
            state       <= state_next;
            hdr_buf     <= hdr_next;
            count       <= count_next;
            only_q      <= only_next;
            proto_error <= err_next;
        end
    end

    // Next-state, handshake outputs and header chunk placement
    always_comb begin
        state_next    = state;
        hdr_next      = hdr_buf;
        count_next    = count;
        only_next     = only_q;
        err_next      = 1'b0;
        flit_in_ready = 1'b0;
        payload_valid = 1'b0;
        payload_last  = 1'b0;

        case (state)
            IDLE: begin
                flit_in_ready = 1'b1;
                if (fire) begin
                    if (ftype == T_HEAD || (ftype == T_HEAD_TAIL && HEADER_FLITS == 1)) begin
                        // A new header always starts from a clean buffer
                        hdr_next                 = '0;
                        hdr_next[BASE_WIDTH-1:0] = fdata;
                        count_next               = CW'(1);
                        if (HEADER_FLITS == 1) begin
                            state_next = HDR_WAIT;
                            only_next  = (ftype == T_HEAD_TAIL);
                        end else begin
                            state_next = HDR;
                        end
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            HDR: begin
                flit_in_ready = 1'b1;
                if (fire) begin
                    if (is_head) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else if (count + 1'b1 == LAST_CNT) begin
                        for (int k = 0; k < HEADER_FLITS; k++) begin
                            if (count == CW'(k))
                                hdr_next[BASE_WIDTH*k +: BASE_WIDTH] = fdata;
                        end
                        count_next = count + 1'b1;
                        only_next  = (ftype == T_TAIL);
                        state_next = HDR_WAIT;
                    end else if (ftype == T_TAIL) begin
                        // Tail arrived before the header was complete
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        for (int k = 0; k < HEADER_FLITS; k++) begin
                            if (count == CW'(k))
                                hdr_next[BASE_WIDTH*k +: BASE_WIDTH] = fdata;
                        end
                        count_next = count + 1'b1;
                    end
                end
            end
            HDR_WAIT: begin
                if (header_accept)
                    state_next = only_q ? IDLE : PAYLOAD;
            end
            PAYLOAD: begin
                flit_in_ready = payload_ready;
                payload_valid = flit_in_valid && !is_head;
                payload_last  = (ftype == T_TAIL);
                if (fire) begin
                    if (is_head) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else if (ftype == T_TAIL) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ni_request_header_assembler.sv
// tb/tb_ni_request_header_assembler.sv - self-checking bench for ni_request_header_assembler
module tb_ni_request_header_assembler;

    localparam logic [1:0] BODY = 2'b00, TAIL = 2'b01, HEAD = 2'b10, HTL = 2'b11;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  flit_in = '0;
    logic         flit_in_valid = 1'b0;
    logic         flit_in_ready;
    logic [89:0]  header;
    logic         header_valid;
    logic         header_accept = 1'b0;
    logic         header_only;
    logic [29:0]  payload_data;
    logic         payload_valid;
    logic         payload_last;
    logic         payload_ready = 1'b0;
    logic         proto_error;

    int n_cmp = 0;
    int n_bad = 0;

    ni_request_header_assembler dut (
        .clock(clock), .reset(reset),
        .flit_in(flit_in), .flit_in_valid(flit_in_valid), .flit_in_ready(flit_in_ready),
        .header(header), .header_valid(header_valid), .header_accept(header_accept),
        .header_only(header_only),
        .payload_data(payload_data), .payload_valid(payload_valid), .payload_last(payload_last),
        .payload_ready(payload_ready), .proto_error(proto_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [1:0]  t;
        logic [29:0] d;
        logic        acc, pr;
        logic        e_rdy, e_hv, e_only, e_pv, e_last, e_err;
        logic [89:0] e_hdr;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [89:0] h3(input logic [29:0] c0, c1, c2);
        return {c2, c1, c0};
    endfunction

    task automatic add(input logic v, input logic [1:0] t, input logic [29:0] d,
                       input logic acc, pr, e_rdy, e_hv, e_only, e_pv, e_last, e_err,
                       input logic [89:0] e_hdr);
        vec_t r;
        r.v = v; r.t = t; r.d = d; r.acc = acc; r.pr = pr;
        r.e_rdy = e_rdy; r.e_hv = e_hv; r.e_only = e_only; r.e_pv = e_pv;
        r.e_last = e_last; r.e_err = e_err; r.e_hdr = e_hdr;
        tbl.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] t, input logic [29:0] d,
                         input logic acc, input logic pr);
        @(negedge clock);
        flit_in_valid = v;
        flit_in       = {t, d};
        header_accept = acc;
        payload_ready = pr;
    endtask

    // Random-test reference: expected header and payload streams per packet
    typedef struct { logic [89:0] h; logic only; } hexp_t;
    typedef struct { logic [29:0] d; logic last; } pexp_t;
    hexp_t      hq[$];
    pexp_t      pq[$];
    logic [31:0] fq[$];

    task automatic gen_packet();
        logic [29:0] c[3];
        int          plen;
        hexp_t       he;
        pexp_t       pe;
        for (int i = 0; i < 3; i++) c[i] = 30'($urandom);
        plen = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 4));
        fq.push_back({HEAD, c[0]});
        fq.push_back({BODY, c[1]});
        fq.push_back({(plen == 0) ? TAIL : BODY, c[2]});
        he.h = {c[2], c[1], c[0]};
        he.only = (plen == 0);
        hq.push_back(he);
        for (int i = 0; i < plen; i++) begin
            pe.d = 30'($urandom);
            pe.last = (i == plen - 1);
            fq.push_back({pe.last ? TAIL : BODY, pe.d});
            pq.push_back(pe);
        end
    endtask

    initial begin
        int idx, cyc;
        hexp_t he;
        pexp_t pe;

        // ---- reset state ----
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        chk("rst_hv", header_valid, 0);
        chk("rst_hdr", header, 0);
        chk("rst_err", proto_error, 0);
        chk("rst_pv", payload_valid, 0);
        chk("rst_rdy", flit_in_ready, 1);
        reset = 1'b0;

        // ---- table: write, read, error packets ----
        //  v  t     d       acc pr  rdy hv only pv last err hdr
        add(1, HEAD, 30'h1,  0, 0,  1, 0, 0, 0, 0, 0, 0);
        add(1, BODY, 30'h2,  0, 0,  1, 0, 0, 0, 0, 0, h3(30'h1, 0, 0));
        add(1, BODY, 30'h3,  0, 0,  1, 0, 0, 0, 0, 0, h3(30'h1, 30'h2, 0));
        add(0, BODY, 30'h0,  0, 0,  0, 1, 0, 0, 0, 0, h3(30'h1, 30'h2, 30'h3));
        add(1, BODY, 30'hA,  1, 0,  0, 1, 0, 0, 0, 0, h3(30'h1, 30'h2, 30'h3));
        add(1, BODY, 30'hA,  0, 0,  0, 0, 0, 1, 0, 0, h3(30'h1, 30'h2, 30'h3));
        add(1, BODY, 30'hA,  0, 1,  1, 0, 0, 1, 0, 0, h3(30'h1, 30'h2, 30'h3));
        add(1, TAIL, 30'hB,  0, 1,  1, 0, 0, 1, 1, 0, h3(30'h1, 30'h2, 30'h3));
        add(1, HEAD, 30'h5,  0, 0,  1, 0, 0, 0, 0, 0, h3(30'h1, 30'h2, 30'h3));
        add(1, BODY, 30'h6,  0, 0,  1, 0, 0, 0, 0, 0, h3(30'h5, 0, 0));
        add(1, TAIL, 30'h7,  0, 0,  1, 0, 0, 0, 0, 0, h3(30'h5, 30'h6, 0));
        add(0, BODY, 30'h0,  1, 0,  0, 1, 1, 0, 0, 0, h3(30'h5, 30'h6, 30'h7));
        add(1, BODY, 30'h9,  0, 0,  1, 0, 0, 0, 0, 0, h3(30'h5, 30'h6, 30'h7));
        add(0, BODY, 30'h0,  0, 0,  1, 0, 0, 0, 0, 1, h3(30'h5, 30'h6, 30'h7));
        add(0, BODY, 30'h0,  0, 0,  1, 0, 0, 0, 0, 0, h3(30'h5, 30'h6, 30'h7));
        add(1, HEAD, 30'h1,  0, 0,  1, 0, 0, 0, 0, 0, h3(30'h5, 30'h6, 30'h7));
        add(1, TAIL, 30'h2,  0, 0,  1, 0, 0, 0, 0, 0, h3(30'h1, 0, 0));
        add(0, BODY, 30'h0,  0, 0,  1, 0, 0, 0, 0, 1, h3(30'h1, 0, 0));
        add(1, HEAD, 30'h11, 0, 0,  1, 0, 0, 0, 0, 0, h3(30'h1, 0, 0));
        add(1, BODY, 30'h12, 0, 0,  1, 0, 0, 0, 0, 0, h3(30'h11, 0, 0));
        add(1, BODY, 30'h13, 0, 0,  1, 0, 0, 0, 0, 0, h3(30'h11, 30'h12, 0));
        add(0, BODY, 30'h0,  1, 0,  0, 1, 0, 0, 0, 0, h3(30'h11, 30'h12, 30'h13));
        add(1, HEAD, 30'h4,  0, 1,  1, 0, 0, 0, 0, 0, h3(30'h11, 30'h12, 30'h13));
        add(0, BODY, 30'h0,  0, 0,  1, 0, 0, 0, 0, 1, h3(30'h11, 30'h12, 30'h13));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].t, tbl[i].d, tbl[i].acc, tbl[i].pr);
            #1;
            chk($sformatf("t%0d_rdy", i), flit_in_ready, tbl[i].e_rdy);
            chk($sformatf("t%0d_hv", i), header_valid, tbl[i].e_hv);
            chk($sformatf("t%0d_only", i), header_valid & header_only, tbl[i].e_only);
            chk($sformatf("t%0d_pv", i), payload_valid, tbl[i].e_pv);
            chk($sformatf("t%0d_last", i), payload_valid & payload_last, tbl[i].e_last);
            chk($sformatf("t%0d_err", i), proto_error, tbl[i].e_err);
            chk($sformatf("t%0d_hdr", i), header, tbl[i].e_hdr);
        end

        // ---- reset while in HDR after two flits ----
        drive(1, HEAD, 30'h21, 0, 0);
        drive(1, BODY, 30'h22, 0, 0);
        drive(0, BODY, 30'h0, 0, 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_rst_hv", header_valid, 0);
        chk("mid_rst_hdr", header, 0);
        drive(1, HEAD, 30'h31, 0, 0);
        drive(1, BODY, 30'h32, 0, 0);
        drive(1, BODY, 30'h33, 0, 0);

        // ---- header backpressure: 5 cycles without accept ----
        for (int i = 0; i < 5; i++) begin
            drive(1, HEAD, 30'h3F, 0, 0);
            #1;
            chk($sformatf("bp%0d_rdy", i), flit_in_ready, 0);
            chk($sformatf("bp%0d_hv", i), header_valid, 1);
            chk($sformatf("bp%0d_hdr", i), header, h3(30'h31, 30'h32, 30'h33));
        end
        drive(0, BODY, 30'h0, 1, 0);
        drive(1, TAIL, 30'h44, 0, 1);
        #1;
        chk("bp_pv", payload_valid, 1);
        chk("bp_pdata", payload_data, 30'h44);
        chk("bp_last", payload_last, 1);
        drive(0, BODY, 30'h0, 0, 0);
        #1;
        chk("bp_idle_pv", payload_valid, 0);

        // ---- back-to-back read packets with accept held high ----
        fq = '{{HEAD, 30'h51}, {BODY, 30'h52}, {TAIL, 30'h53},
               {HEAD, 30'h61}, {BODY, 30'h62}, {TAIL, 30'h63}};
        idx = 0;
        cyc = 0;
        while (idx < 6 && cyc < 20) begin
            drive(1, fq[idx][31:30], fq[idx][29:0], 1, 0);
            #1;
            if (flit_in_ready) idx++;
            cyc++;
        end
        chk("b2b_cycles", cyc, 7);
        drive(0, BODY, 30'h0, 1, 0);
        drive(0, BODY, 30'h0, 0, 0);
        fq.delete();

        // ---- randomized packets against the packet-level model ----
        for (int p = 0; p < 40; p++) gen_packet();
        idx = 0;
        cyc = 0;
        while ((idx < fq.size() || hq.size() != 0 || pq.size() != 0) && cyc < 20000) begin
            @(negedge clock);
            header_accept = ($urandom_range(0, 2) != 0);
            payload_ready = ($urandom_range(0, 2) != 0);
            flit_in_valid = (idx < fq.size()) && ($urandom_range(0, 3) != 0);
            flit_in       = (idx < fq.size()) ? fq[idx] : 32'h0;
            #1;
            if (header_valid && header_accept) begin
                if (hq.size() == 0) begin
                    chk("rnd_hdr_extra", 1, 0);
                end else begin
                    he = hq.pop_front();
                    chk("rnd_hdr", header, he.h);
                    chk("rnd_only", header_only, he.only);
                end
            end
            if (payload_valid && payload_ready) begin
                if (pq.size() == 0) begin
                    chk("rnd_pay_extra", 1, 0);
                end else begin
                    pe = pq.pop_front();
                    chk("rnd_pdata", payload_data, pe.d);
                    chk("rnd_plast", payload_last, pe.last);
                end
            end
            if (proto_error) chk("rnd_err", proto_error, 0);
            if (flit_in_valid && flit_in_ready) idx++;
            cyc++;
        end
        chk("rnd_timeout", cyc < 20000, 1);
        chk("rnd_hdr_left", hq.size(), 0);
        chk("rnd_pay_left", pq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
